// File: rtl/noc16_result_sink.sv
// Result sink for a NoC16 receive port: good frames go into a show-ahead FIFO,
// bad-command frames are counted and dropped, and sticky error flags are kept.
module noc16_result_sink #(
  parameter logic [7:0] EXPECT_CMD = 8'hEF,
  parameter int         DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] Ksubs3_Noc16_RxData_lo,
  input  logic [7:0]  Ksubs3_Noc16_RxData_cmd,
  input  logic        Ksubs3_Noc16_RxData_valid,
  output logic        Ksubs3_Noc16_RxData_rdy,
  input  logic        pop,
  output logic        result_valid,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic [15:0] frame_count,
  output logic [7:0]  bad_cmd_count,
  output logic [7:0]  ksubsAbendSyndrome,
  output logic [7:0]  ksubsGpioLeds
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] occ_t;
  localparam occ_t FULL = occ_t'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  occ_t          occupancy;
  logic [63:0]   last_q;
  logic          syn_bad_cmd;
  logic          syn_underflow;
  logic          syn_wrap;

  logic accept;
  logic good;
  logic bad;
  logic pop_ok;
  logic underflow;
  logic [63:0] head;

  // Ready is gated by reset so nothing is consumed while the block is held.
  assign Ksubs3_Noc16_RxData_rdy = (occupancy != FULL) && !reset;
  assign accept    = Ksubs3_Noc16_RxData_valid && Ksubs3_Noc16_RxData_rdy;
  assign good      = accept && (Ksubs3_Noc16_RxData_cmd == EXPECT_CMD);
  assign bad       = accept && (Ksubs3_Noc16_RxData_cmd != EXPECT_CMD);
  assign result_valid = (occupancy != '0);
  assign pop_ok    = pop && result_valid;
  assign underflow = pop && !result_valid;
  assign head      = mem[rd_ptr];

  // When empty, present the last popped entry (zero after reset).
  assign {result_hi, result_lo} = result_valid ? head : last_q;
  assign ksubsAbendSyndrome = {syn_wrap, 5'b0, syn_underflow, syn_bad_cmd};

  // NOTE: the storage array carries no reset; occupancy gates every read, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (good) mem[wr_ptr] <= Ksubs3_Noc16_RxData_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      last_q        <= '0;
      frame_count   <= '0;
      bad_cmd_count <= '0;
      ksubsGpioLeds <= '0;
      syn_bad_cmd   <= 1'b0;
      syn_underflow <= 1'b0;
      syn_wrap      <= 1'b0;
    end else begin
      if (good) begin
        wr_ptr      <= wr_ptr + 1'b1;
        frame_count <= frame_count + 16'd1;
        if (frame_count == 16'hFFFF) syn_wrap <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr        <= rd_ptr + 1'b1;
        last_q        <= head;
        ksubsGpioLeds <= head[7:0];
      end
      case ({good, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (bad) begin
        syn_bad_cmd <= 1'b1;
        if (bad_cmd_count != 8'hFF) bad_cmd_count <= bad_cmd_count + 8'd1;
      end
      if (underflow) syn_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc16_result_sink.sv
// Directed bench for noc16_result_sink: inputs change and outputs are sampled
// on the falling edge, so every check sees state settled after a rising edge.
module tb_noc16_result_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rx_lo;
  logic [7:0]  rx_cmd;
  logic        rx_valid;
  logic        rx_rdy;
  logic        pop;
  logic        result_valid;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic [15:0] frame_count;
  logic [7:0]  bad_cmd_count;
  logic [7:0]  syndrome;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_fails  = 0;

  noc16_result_sink dut (
    .clk                       (clk),
    .reset                     (reset),
    .Ksubs3_Noc16_RxData_lo    (rx_lo),
    .Ksubs3_Noc16_RxData_cmd   (rx_cmd),
    .Ksubs3_Noc16_RxData_valid (rx_valid),
    .Ksubs3_Noc16_RxData_rdy   (rx_rdy),
    .pop                       (pop),
    .result_valid              (result_valid),
    .result_hi                 (result_hi),
    .result_lo                 (result_lo),
    .frame_count               (frame_count),
    .bad_cmd_count             (bad_cmd_count),
    .ksubsAbendSyndrome        (syndrome),
    .ksubsGpioLeds             (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] cmd, input logic [63:0] data);
    rx_cmd   = cmd;
    rx_lo    = data;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    cyc();
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_lo = '0; rx_cmd = '0; rx_valid = 1'b0; pop = 1'b0;
    @(negedge clk);
    // Reset state, with valid presented to show rdy stays low under reset
    rx_valid = 1'b1; rx_cmd = 8'hEF;
    cyc();
    check("rst_rdy", rx_rdy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", {result_hi, result_lo}, 0);
    check("rst_frames", frame_count, 0);
    check("rst_bad", bad_cmd_count, 0);
    check("rst_syn", syndrome, 0);
    check("rst_leds", leds, 0);
    rx_valid = 1'b0;
    reset = 1'b0;
    cyc();
    check("post_rst_rdy", rx_rdy, 1);
    check("post_rst_valid", result_valid, 0);

    // Single good frame, one-cycle latency, then pop
    push_one(8'hEF, 64'h0000_0001_0000_000A);
    check("single_valid", result_valid, 1);
    check("single_hi", result_hi, 32'h1);
    check("single_lo", result_lo, 32'hA);
    check("single_frames", frame_count, 1);
    pop_one();
    check("single_pop_valid", result_valid, 0);
    check("single_pop_leds", leds, 8'h0A);
    check("single_hold_lo", result_lo, 32'hA);

    // Bad command frames
    push_one(8'h12, 64'hDEAD);
    check("bad_valid", result_valid, 0);
    check("bad_count1", bad_cmd_count, 1);
    check("bad_syn", syndrome, 8'h01);
    rx_cmd = 8'h12; rx_valid = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    rx_valid = 1'b0;
    check("bad_sat", bad_cmd_count, 8'hFF);
    check("bad_frames", frame_count, 1);
    check("bad_no_result", result_valid, 0);

    // Underflow pop
    pop_one();
    check("uf_syn", syndrome, 8'h03);
    check("uf_valid", result_valid, 0);
    check("uf_lo", result_lo, 32'hA);
    check("uf_leds", leds, 8'h0A);

    // Fill and backpressure: 5 back-to-back frames into depth 4
    rx_cmd = 8'hEF; rx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      rx_lo = 64'(i);
      cyc();
    end
    check("full_rdy", rx_rdy, 0);
    check("full_frames", frame_count, 5);
    check("full_head", result_lo, 1);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    check("full_pop_rdy", rx_rdy, 1);
    check("full_pop_leds", leds, 1);
    check("full_pop_frames", frame_count, 5);
    check("full_pop_head", result_lo, 2);
    cyc();
    rx_valid = 1'b0;
    check("held_accepted", frame_count, 6);
    check("refull_rdy", rx_rdy, 0);
    for (int v = 2; v <= 5; v++) begin
      check("drain_head", result_lo, 32'(v));
      pop_one();
      check("drain_leds", leds, 8'(v));
    end
    check("drain_empty", result_valid, 0);
    check("drain_rdy", rx_rdy, 1);

    // Simultaneous push and pop at occupancy 2
    push_one(8'hEF, 64'h10);
    push_one(8'hEF, 64'h11);
    rx_lo = 64'h12; rx_valid = 1'b1; pop = 1'b1;
    cyc();
    rx_valid = 1'b0; pop = 1'b0;
    check("sim_leds", leds, 8'h10);
    check("sim_head", result_lo, 32'h11);
    check("sim_frames", frame_count, 9);
    pop_one();
    check("sim_second", result_lo, 32'h12);
    pop_one();
    check("sim_empty", result_valid, 0);
    check("sim_leds_last", leds, 8'h12);

    // Asynchronous reset with three entries queued
    push_one(8'hEF, 64'h20);
    push_one(8'hEF, 64'h21);
    push_one(8'hEF, 64'h22);
    check("pre_arst_head", result_lo, 32'h20);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", result_valid, 0);
    check("arst_frames", frame_count, 0);
    check("arst_bad", bad_cmd_count, 0);
    check("arst_syn", syndrome, 0);
    check("arst_lo", result_lo, 0);
    check("arst_rdy", rx_rdy, 0);
    @(negedge clk);
    cyc();
    reset = 1'b0;
    push_one(8'hEF, 64'h0000_0007_0000_0030);
    check("after_arst_head", result_lo, 32'h30);
    check("after_arst_hi", result_hi, 32'h7);
    check("after_arst_frames", frame_count, 1);
    pop_one();
    check("after_arst_leds", leds, 8'h30);
    check("after_arst_empty", result_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
